dmi_bus_master: RTL and testbench
=================================

# dmi_bus_master

Executes debug requests delivered by the 64-bit request/response CDC register on the system side (clk2 domain). Each request is {addr[23:0], data[31:0], op[7:0]}; the block turns it into one system-bus read or write, guards it with a timeout, and returns exactly one response per request to the CDC. It sits directly downstream of the CDC's `req_*_ck2` outputs and directly upstream of its `resp_*_ck2` inputs.

## Interface
- TIMEOUT_CYCLES, 255: cycles from entering BUS_REQ until timeout (≥2).
- clk2  in  1  system clock; all logic on posedge.
- rst_ck2  in  1  reset, synchronous, active-high.
- req_vld_ck2  in  1  request valid.
- req_rdy_ck2  out  1  request ready.
- req_addr_ck2  in  24  request address.
- req_data_ck2  in  32  write data.
- req_op_ck2  in  8  opcode.
- resp_vld_ck2  out  1  response valid.
- resp_rdy_ck2  in  1  response ready.
- resp_addr_ck2  out  24  echoed request address.
- resp_data_ck2  out  32  read data, else 0.
- resp_op_ck2  out  8  status.
- bus_req_vld  out  1  bus command valid.
- bus_req_rdy  in  1  bus command accepted.
- bus_we  out  1  1 = write.
- bus_addr  out  24  bus address.
- bus_wdata  out  32  bus write data.
- bus_rvld  in  1  completion (read data or write ack).
- bus_rdata  in  32  read data.
- bus_err  in  1  error, qualified by bus_rvld.

## Operation
- Opcodes: OP_NOP=0, OP_READ=1, OP_WRITE=2; any other value is illegal. Status: STS_OK=0, STS_ERR=2, STS_TIMEOUT=3.
- Request fire = req_vld_ck2 & req_rdy_ck2; addr/data/op are latched on fire.
- req_rdy_ck2 = (state==IDLE) | (state==RESP & resp_rdy_ck2). A response and the next request may fire in the same cycle.
- States:
  - IDLE: on fire, READ/WRITE → BUS_REQ; NOP → RESP with STS_OK; illegal → RESP with STS_ERR. No bus access occurs for NOP or illegal ops.
  - BUS_REQ: bus_req_vld = !orphan, carrying the latched command. On bus_req_vld & bus_req_rdy → BUS_WAIT.
  - BUS_WAIT: on bus_rvld → RESP. Status is STS_ERR if bus_err, else STS_OK. resp_data = bus_rdata for a read with no error, else 0.
  - RESP: resp_vld_ck2=1, outputs held stable. On resp fire → IDLE, or → the next state per IDLE rules if a new request fires in the same cycle.
- Timeout counter, width $clog2(TIMEOUT_CYCLES+1):
  - Cleared on entering BUS_REQ; increments every cycle in BUS_REQ/BUS_WAIT.
  - If it reaches TIMEOUT_CYCLES-1 with no completion that cycle → RESP with STS_TIMEOUT, data 0. bus_req_vld drops in the same cycle.
- Orphan flag:
  - Set on a timeout in BUS_WAIT (command accepted, completion still pending); not set on a timeout in BUS_REQ.
  - The next bus_rvld while orphan=1 is discarded and clears the flag.
  - A new BUS_REQ holds bus_req_vld low until orphan clears; the timeout counter keeps running during that hold.
- bus_rvld outside BUS_WAIT with orphan=0 is ignored.

## Timing
- Reset values: state IDLE, orphan 0, counter 0; req_rdy_ck2=1; resp_vld_ck2=0; bus_req_vld=0; bus_we=0; all data/addr/op outputs 0.
- All outputs are registered or decoded from state only, except req_rdy_ck2, which also depends on resp_rdy_ck2.
- The bus must not assert bus_rvld in the cycle its command is accepted.
- Latencies, request fire at cycle T:
  - Zero-wait read: bus_req_vld at T+1 (accepted), bus_rvld at T+2, resp_vld_ck2 at T+3.
  - NOP or illegal op: resp_vld_ck2 at T+1.
- Completion and timeout in the same cycle: completion wins.
- A reset asserted mid-transaction returns the block to IDLE and clears orphan; the bus side is responsible for abandoning any in-flight completion.

## Structure
- Package dm_bus_pkg: OP_* and STS_* constants (8-bit) and the state enum {IDLE, BUS_REQ, BUS_WAIT, RESP}. The CDC-side bench imports it as well.
- Single module, no sub-modules. The timeout counter is inline.

## Test plan
- Read 0x000010, bus returns 0xDEADBEEF after 3 wait cycles → response addr 0x000010, data 0xDEADBEEF, op 0.
- Write 0x000020 / 0x12345678, bus_req_rdy low for 5 cycles, then ack → bus_we=1 with correct wdata; response op 0, data 0.
- NOP, then op 0x7F → responses at T+1: op 0 and op 2 respectively; bus_req_vld never asserted.
- TIMEOUT_CYCLES=8, read accepted, bus_rvld withheld → resp op 3 exactly 8 cycles after entering BUS_REQ. Late bus_rvld is discarded, and the next read waits for it before issuing.
- bus_rvld with bus_err=1 on read → op 2, data 0. Completion and timeout in the same cycle → op 0.
- resp_rdy_ck2 held high with back-to-back requests → a new request is accepted in the RESP fire cycle; no response is lost or duplicated. Reset mid-BUS_WAIT → IDLE with reset outputs next cycle.

Source files
------------

// File: rtl/dm_bus_pkg.sv
// Shared opcode/status encodings and FSM states for the debug-module system-bus master.
// Imported by the bus master RTL and by the CDC-side benches.
package dm_bus_pkg;

    localparam logic [7:0] OP_NOP      = 8'h00;
    localparam logic [7:0] OP_READ     = 8'h01;
    localparam logic [7:0] OP_WRITE    = 8'h02;

    localparam logic [7:0] STS_OK      = 8'h00;
    localparam logic [7:0] STS_ERR     = 8'h02;
    localparam logic [7:0] STS_TIMEOUT = 8'h03;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUS_REQ  = 2'd1,
        BUS_WAIT = 2'd2,
        RESP     = 2'd3
    } dm_state_e;

    typedef struct packed {
        logic [23:0] addr;
        logic [31:0] data;
        logic [7:0]  op;
    } dm_req_t;

    function automatic logic op_is_bus(input logic [7:0] op);
        return (op == OP_READ) || (op == OP_WRITE);
    endfunction

endpackage

// File: rtl/dmi_bus_master_if.sv
// Request/response handshake with the CDC plus the system-bus command/completion signals.
// master = the bus master block's view, slave = the surrounding CDC + bus.
interface dmi_bus_master_if;

    logic        req_vld_ck2;
    logic        req_rdy_ck2;
    logic [23:0] req_addr_ck2;
    logic [31:0] req_data_ck2;
    logic [7:0]  req_op_ck2;

    logic        resp_vld_ck2;
    logic        resp_rdy_ck2;
    logic [23:0] resp_addr_ck2;
    logic [31:0] resp_data_ck2;
    logic [7:0]  resp_op_ck2;

    logic        bus_req_vld;
    logic        bus_req_rdy;
    logic        bus_we;
    logic [23:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_rvld;
    logic [31:0] bus_rdata;
    logic        bus_err;

    modport master (
        input  req_vld_ck2, req_addr_ck2, req_data_ck2, req_op_ck2, resp_rdy_ck2,
               bus_req_rdy, bus_rvld, bus_rdata, bus_err,
        output req_rdy_ck2, resp_vld_ck2, resp_addr_ck2, resp_data_ck2, resp_op_ck2,
               bus_req_vld, bus_we, bus_addr, bus_wdata
    );

    modport slave (
        output req_vld_ck2, req_addr_ck2, req_data_ck2, req_op_ck2, resp_rdy_ck2,
               bus_req_rdy, bus_rvld, bus_rdata, bus_err,
        input  req_rdy_ck2, resp_vld_ck2, resp_addr_ck2, resp_data_ck2, resp_op_ck2,
               bus_req_vld, bus_we, bus_addr, bus_wdata
    );

endinterface

// File: rtl/dmi_bus_master.sv
// Turns one CDC debug request into one system-bus read/write with a timeout guard,
// returning exactly one response per request.
module dmi_bus_master
    import dm_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk2,
    input  logic             rst_ck2,
    dmi_bus_master_if.master dmi
);

    localparam int            CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    dm_state_e     state_q, state_d;
    logic          orphan_q, orphan_d;
    logic [CW-1:0] cnt_q, cnt_d;
    dm_req_t       req_q, req_d;
    logic          we_q, we_d;
    logic [31:0]   resp_data_q, resp_data_d;
    logic [7:0]    resp_op_q, resp_op_d;

    logic req_rdy, req_fire, tmo_hit, bus_req_vld, bus_fire;

    assign req_rdy  = (state_q == IDLE) || ((state_q == RESP) && dmi.resp_rdy_ck2);
    assign req_fire = dmi.req_vld_ck2 && req_rdy;
    assign tmo_hit  = (cnt_q == TMO_LAST);

    // Command is withheld while a timed-out completion is still owed, and on the
    // timeout cycle itself so the bus never accepts a command we are abandoning.
    assign bus_req_vld = (state_q == BUS_REQ) && !orphan_q && !tmo_hit;
    assign bus_fire    = bus_req_vld && dmi.bus_req_rdy;

    always_comb begin
        state_d     = state_q;
        orphan_d    = orphan_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        we_d        = we_q;
        resp_data_d = resp_data_q;
        resp_op_d   = resp_op_q;

        if (orphan_q && dmi.bus_rvld)
            orphan_d = 1'b0;

        unique case (state_q)
            IDLE: ;
            BUS_REQ: begin
                cnt_d = cnt_q + CW'(1);
                if (bus_fire) begin
                    state_d = BUS_WAIT;
                end else if (tmo_hit) begin
                    state_d     = RESP;
                    resp_op_d   = STS_TIMEOUT;
                    resp_data_d = '0;
                end
            end
            BUS_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                // A completion on the last counted cycle still wins over the timeout.
                if (dmi.bus_rvld) begin
                    state_d     = RESP;
                    resp_op_d   = dmi.bus_err ? STS_ERR : STS_OK;
                    resp_data_d = (req_q.op == OP_READ && !dmi.bus_err) ? dmi.bus_rdata : '0;
                end else if (tmo_hit) begin
                    state_d     = RESP;
                    resp_op_d   = STS_TIMEOUT;
                    resp_data_d = '0;
                    orphan_d    = 1'b1;
                end
            end
            RESP: begin
                if (dmi.resp_rdy_ck2)
                    state_d = IDLE;
            end
        endcase

        // Only reachable from IDLE or from a firing RESP, so it overrides the case above.
        if (req_fire) begin
            req_d.addr = dmi.req_addr_ck2;
            req_d.data = dmi.req_data_ck2;
            req_d.op   = dmi.req_op_ck2;
            we_d       = (dmi.req_op_ck2 == OP_WRITE);
            cnt_d      = '0;
            if (op_is_bus(dmi.req_op_ck2)) begin
                state_d = BUS_REQ;
            end else begin
                state_d     = RESP;
                resp_op_d   = (dmi.req_op_ck2 == OP_NOP) ? STS_OK : STS_ERR;
                resp_data_d = '0;
            end
        end
    end

    always_ff @(posedge clk2) begin
        if (rst_ck2) begin
            state_q     <= IDLE;
            orphan_q    <= 1'b0;
            cnt_q       <= '0;
            req_q       <= '0;
            we_q        <= 1'b0;
            resp_data_q <= '0;
            resp_op_q   <= '0;
        end else begin
            state_q     <= state_d;
            orphan_q    <= orphan_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            we_q        <= we_d;
            resp_data_q <= resp_data_d;
            resp_op_q   <= resp_op_d;
        end
    end

    assign dmi.req_rdy_ck2   = req_rdy;
    assign dmi.resp_vld_ck2  = (state_q == RESP);
    assign dmi.resp_addr_ck2 = req_q.addr;
    assign dmi.resp_data_ck2 = resp_data_q;
    assign dmi.resp_op_ck2   = resp_op_q;
    assign dmi.bus_req_vld   = bus_req_vld;
    assign dmi.bus_we        = we_q;
    assign dmi.bus_addr      = req_q.addr;
    assign dmi.bus_wdata     = req_q.data;

endmodule

// File: tb/tb_dmi_bus_master.sv
// Bench for dmi_bus_master: directed cases plus randomized transactions, each response
// predicted from opcode, bus ready delay and completion delay.
module tb_dmi_bus_master;
    import dm_bus_pkg::*;

    localparam int TMO = 8;

    logic clk2 = 1'b0;
    logic rst_ck2;
    always #5 clk2 = ~clk2;

    dmi_bus_master_if dmi();

    dmi_bus_master #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk2    (clk2),
        .rst_ck2 (rst_ck2),
        .dmi     (dmi)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk2) cyc <= cyc + 1;

    // Bus-side completion schedule (absolute cycle of the next bus_rvld pulse).
    int          rvld_at = -1;
    logic [31:0] rv_data = '0;
    bit          rv_err  = 1'b0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk2);
        #1;
    endtask

    task automatic bus_cycle(input bit rdy);
        dmi.bus_req_rdy = rdy;
        dmi.bus_rvld    = (cyc == rvld_at);
        dmi.bus_rdata   = dmi.bus_rvld ? rv_data : $urandom;
        dmi.bus_err     = dmi.bus_rvld ? rv_err : 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            step();
            dmi.req_vld_ck2  = 1'b0;
            dmi.resp_rdy_ck2 = 1'b0;
            bus_cycle(1'b0);
            #1;
            chk("idle_resp_vld", 64'(dmi.resp_vld_ck2), 64'(0));
            chk("idle_bus_vld", 64'(dmi.bus_req_vld), 64'(0));
        end
    endtask

    // Outcome of one request from the request's own terms: the bus raises ready d1
    // cycles into the command phase and completes d2 cycles after acceptance.
    function automatic void predict(input logic [7:0] op, input int d1, input int d2,
                                    input bit err, input logic [31:0] rdata,
                                    output int lat, output logic [7:0] sts,
                                    output logic [31:0] dat, output int acc_o, output bit orph);
        lat = 1; sts = STS_OK; dat = '0; acc_o = -1; orph = 1'b0;
        if (op != OP_READ && op != OP_WRITE) begin
            sts = (op == OP_NOP) ? STS_OK : STS_ERR;
        end else if (d1 > TMO - 2) begin
            lat = TMO + 1;
            sts = STS_TIMEOUT;
        end else begin
            acc_o = d1;
            if (d1 + d2 <= TMO - 1) begin
                lat = d1 + d2 + 2;
                sts = err ? STS_ERR : STS_OK;
                dat = (op == OP_READ && !err) ? rdata : 32'h0;
            end else begin
                lat  = TMO + 1;
                sts  = STS_TIMEOUT;
                orph = 1'b1;
            end
        end
    endfunction

    // Presents a request in the current cycle, plays the bus, checks the response.
    // Returns in the cycle the response fires (resp_rdy_ck2 driven high).
    task automatic run_txn(input logic [7:0] op, input logic [23:0] addr, input logic [31:0] data,
                           input int d1, input int d2, input bit err, input logic [31:0] rdata,
                           input int rdly, input bit keep_rdy, input bit rdy_early,
                           output bit orph);
        int f, lat, exp_acc, acc_o;
        bit acc, saw_vld;
        logic [7:0] sts;
        logic [31:0] edat;
        predict(op, d1, d2, err, rdata, lat, sts, edat, exp_acc, orph);
        dmi.req_vld_ck2  = 1'b1;
        dmi.req_addr_ck2 = addr;
        dmi.req_data_ck2 = data;
        dmi.req_op_ck2   = op;
        bus_cycle(1'b0);
        #1;
        chk("req_rdy", 64'(dmi.req_rdy_ck2), 64'(1));
        f = cyc; acc = 1'b0; acc_o = -1; saw_vld = 1'b0;
        for (int o = 0; o < 40; o++) begin
            step();
            dmi.req_vld_ck2  = 1'b0;
            dmi.req_addr_ck2 = 24'($urandom);
            dmi.req_data_ck2 = $urandom;
            dmi.req_op_ck2   = 8'($urandom);
            dmi.resp_rdy_ck2 = keep_rdy;
            bus_cycle(!acc && (rdy_early || o >= d1));
            #1;
            if (dmi.bus_req_vld) saw_vld = 1'b1;
            if (dmi.bus_req_vld && dmi.bus_req_rdy && !acc) begin
                acc = 1'b1; acc_o = o;
                rvld_at = cyc + d2; rv_data = rdata; rv_err = err;
                chk("bus_we", 64'(dmi.bus_we), 64'(op == OP_WRITE));
                chk("bus_addr", 64'(dmi.bus_addr), 64'(addr));
                if (op == OP_WRITE) chk("bus_wdata", 64'(dmi.bus_wdata), 64'(data));
            end
            if (dmi.resp_vld_ck2) break;
        end
        chk("resp_lat", 64'(cyc - f), 64'(lat));
        chk("resp_addr", 64'(dmi.resp_addr_ck2), 64'(addr));
        chk("resp_op", 64'(dmi.resp_op_ck2), 64'(sts));
        chk("resp_data", 64'(dmi.resp_data_ck2), 64'(edat));
        chk("acc_off", 64'(acc_o), 64'(exp_acc));
        if (op != OP_READ && op != OP_WRITE) chk("no_bus", 64'(saw_vld), 64'(0));
        if (!keep_rdy) begin
            repeat (rdly) begin
                step();
                dmi.resp_rdy_ck2 = 1'b0;
                bus_cycle(1'b0);
                #1;
            end
            if (rdly > 0)
                chk("resp_hold", {23'h0, dmi.resp_vld_ck2, dmi.resp_op_ck2, dmi.resp_data_ck2},
                    {23'h0, 1'b1, sts, edat});
            dmi.resp_rdy_ck2 = 1'b1;
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        bit orph;
        logic [7:0] op;
        rst_ck2 = 1'b1;
        dmi.req_vld_ck2 = 1'b0; dmi.req_addr_ck2 = '0; dmi.req_data_ck2 = '0; dmi.req_op_ck2 = '0;
        dmi.resp_rdy_ck2 = 1'b0;
        dmi.bus_req_rdy = 1'b0; dmi.bus_rvld = 1'b0; dmi.bus_rdata = '0; dmi.bus_err = 1'b0;
        repeat (3) step();
        chk("rst_req_rdy", 64'(dmi.req_rdy_ck2), 64'(1));
        chk("rst_resp_vld", 64'(dmi.resp_vld_ck2), 64'(0));
        chk("rst_bus_vld", 64'(dmi.bus_req_vld), 64'(0));
        chk("rst_bus_we", 64'(dmi.bus_we), 64'(0));
        chk("rst_outs", {dmi.resp_addr_ck2, dmi.resp_op_ck2, dmi.resp_data_ck2},
            {24'h0, 8'h0, 32'h0});
        chk("rst_bus_outs", {8'h0, dmi.bus_addr, dmi.bus_wdata}, 64'h0);
        rst_ck2 = 1'b0;
        idle(2);

        // Read with 3 wait cycles, write with ready held off 5 cycles.
        run_txn(OP_READ, 24'h000010, 32'h0, 0, 4, 1'b0, 32'hDEADBEEF, 0, 1'b0, 1'b0, orph);
        idle(1);
        run_txn(OP_WRITE, 24'h000020, 32'h12345678, 5, 1, 1'b0, 32'h0, 1, 1'b0, 1'b0, orph);
        idle(1);
        // NOP and illegal op.
        run_txn(OP_NOP, 24'h000abc, 32'h1, 0, 1, 1'b0, 32'h0, 0, 1'b0, 1'b0, orph);
        idle(1);
        run_txn(8'h7F, 24'h000def, 32'h2, 0, 1, 1'b0, 32'h0, 2, 1'b0, 1'b0, orph);
        idle(1);
        // Bus error, and completion on the timeout cycle.
        run_txn(OP_READ, 24'h000030, 32'h0, 1, 2, 1'b1, 32'h55AA55AA, 0, 1'b0, 1'b0, orph);
        idle(1);
        run_txn(OP_READ, 24'h000040, 32'h0, 2, 5, 1'b0, 32'h0A0B0C0D, 0, 1'b0, 1'b0, orph);
        idle(1);

        // Timeout after acceptance; the late completion is discarded and the next
        // read is held back until it arrives.
        run_txn(OP_READ, 24'h000050, 32'h0, 0, 99, 1'b0, 32'h0, 0, 1'b0, 1'b0, orph);
        chk("orphan_pred", 64'(orph), 64'(1));
        rvld_at = cyc + 3; rv_data = 32'hBAD0BAD0; rv_err = 1'b0;
        run_txn(OP_READ, 24'h000060, 32'h0, 3, 2, 1'b0, 32'hCAFEF00D, 0, 1'b0, 1'b1, orph);
        idle(1);

        // Timeout without acceptance leaves no orphan: next read issues at once.
        run_txn(OP_READ, 24'h000070, 32'h0, 99, 1, 1'b0, 32'h0, 0, 1'b0, 1'b0, orph);
        run_txn(OP_READ, 24'h000080, 32'h0, 0, 1, 1'b0, 32'h13579BDF, 0, 1'b0, 1'b1, orph);
        idle(1);

        // Stray completion while idle is ignored.
        rvld_at = cyc + 1; rv_data = 32'hFFFFFFFF; rv_err = 1'b1;
        idle(2);
        run_txn(OP_READ, 24'h000090, 32'h0, 0, 1, 1'b0, 32'h24680ACE, 0, 1'b0, 1'b0, orph);

        // Back-to-back with resp_rdy_ck2 held high.
        run_txn(OP_READ, 24'h0000A0, 32'h0, 0, 1, 1'b0, 32'h11111111, 0, 1'b1, 1'b0, orph);
        run_txn(OP_NOP, 24'h0000A1, 32'h0, 0, 1, 1'b0, 32'h0, 0, 1'b1, 1'b0, orph);
        run_txn(OP_WRITE, 24'h0000A2, 32'h22222222, 1, 2, 1'b0, 32'h0, 0, 1'b1, 1'b0, orph);
        run_txn(8'hC3, 24'h0000A3, 32'h0, 0, 1, 1'b0, 32'h0, 0, 1'b1, 1'b0, orph);
        run_txn(OP_READ, 24'h0000A4, 32'h0, 0, 3, 1'b0, 32'h33333333, 0, 1'b1, 1'b0, orph);
        idle(2);

        // Reset while waiting for a completion.
        dmi.req_vld_ck2 = 1'b1; dmi.req_op_ck2 = OP_READ; dmi.req_addr_ck2 = 24'h000555;
        bus_cycle(1'b0);
        step();
        dmi.req_vld_ck2 = 1'b0;
        bus_cycle(1'b1);
        #1;
        chk("rst_mid_accept", 64'(dmi.bus_req_vld), 64'(1));
        step();
        bus_cycle(1'b0);
        rst_ck2 = 1'b1;
        step();
        rst_ck2 = 1'b0;
        bus_cycle(1'b0);
        #1;
        chk("rst_mid_rdy", {62'h0, dmi.req_rdy_ck2, dmi.resp_vld_ck2}, {62'h0, 1'b1, 1'b0});
        chk("rst_mid_bus", {38'h0, dmi.bus_req_vld, dmi.bus_we, dmi.bus_addr}, 64'h0);
        chk("rst_mid_resp", {dmi.resp_addr_ck2, dmi.resp_op_ck2, dmi.resp_data_ck2}, 64'h0);
        idle(1);
        run_txn(OP_READ, 24'h0000B0, 32'h0, 0, 2, 1'b0, 32'h89ABCDEF, 0, 1'b0, 1'b0, orph);

        // Randomized transactions.
        for (int i = 0; i < 40; i++) begin
            int r;
            if (orph) begin
                while (cyc <= rvld_at) idle(1);
            end else if ($urandom_range(0, 1) == 0) begin
                idle($urandom_range(1, 2));
            end
            r = $urandom_range(0, 9);
            op = (r == 0) ? OP_NOP : (r == 1) ? 8'($urandom_range(3, 255)) :
                 (r < 6) ? OP_READ : OP_WRITE;
            run_txn(op, 24'($urandom), $urandom, $urandom_range(0, 5), $urandom_range(1, 9),
                    ($urandom_range(0, 3) == 0), $urandom, $urandom_range(0, 2),
                    ($urandom_range(0, 2) == 0), 1'b0, orph);
        end
        if (orph) begin
            while (cyc <= rvld_at) idle(1);
        end
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
